// File: rtl/ful_mac_ctrl.sv
// rtl/ful_mac_ctrl.sv - three-group MAC controller sweeping a weight ROM per output neuron
module ful_mac_ctrl #(
    parameter int N_FEAT = 30,
    parameter int N_OUT  = 16,
    parameter int FRAC   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               feat_wr_en,
    input  logic [4:0]         feat_wr_addr,
    input  logic signed [15:0] feat_wr_data [3:1],
    output logic [4:0]         count_ful,
    output logic [4:0]         count_finish,
    input  logic signed [15:0] weight_ful1 [3:1],
    output logic               busy,
    output logic               out_valid,
    output logic [4:0]         out_idx,
    output logic signed [15:0] out_data,
    output logic               done
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [4:0]         count_ful_q, count_ful_d;
    logic [4:0]         count_finish_q, count_finish_d;
    logic signed [39:0] acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic [4:0]         out_idx_q, out_idx_d;
    logic signed [15:0] out_data_q, out_data_d;
    logic signed [15:0] feat_q [1:3][1:N_FEAT];

    logic               feat_we;
    logic signed [31:0] prod [1:3];
    logic signed [39:0] total;
    logic signed [39:0] shifted;
    logic signed [15:0] sat;
    logic               last_step;
    logic               last_neuron;

    assign feat_we = (state_q == S_IDLE) && feat_wr_en &&
                     (feat_wr_addr != 5'd0) && (int'(feat_wr_addr) <= N_FEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 1; g <= 3; g++)
                for (int a = 1; a <= N_FEAT; a++)
                    feat_q[g][a] <= '0;
        end else if (feat_we) begin
            for (int g = 1; g <= 3; g++)
                feat_q[g][feat_wr_addr] <= feat_wr_data[g];
        end
    end

    // count_ful is only a valid buffer index in RUN, so products are gated there
    always_comb begin
        for (int g = 1; g <= 3; g++) begin
            prod[g] = 32'sd0;
            if (state_q == S_RUN)
                prod[g] = 32'(feat_q[g][count_ful_q]) * 32'(weight_ful1[g]);
        end
    end

    assign total   = acc_q + 40'(prod[1]) + 40'(prod[2]) + 40'(prod[3]);
    assign shifted = total >>> FRAC;

    always_comb begin
        sat = shifted[15:0];
        if (shifted > 40'sd32767)
            sat = 16'sh7fff;
        else if (shifted < -40'sd32768)
            sat = 16'sh8000;
    end

    assign last_step   = (count_ful_q == 5'(N_FEAT));
    assign last_neuron = (count_finish_q == 5'(N_OUT));

    always_comb begin
        state_d        = state_q;
        count_ful_d    = count_ful_q;
        count_finish_d = count_finish_q;
        acc_d          = acc_q;
        out_valid_d    = 1'b0;
        done_d         = 1'b0;
        out_idx_d      = out_idx_q;
        out_data_d     = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_RUN;
                    count_ful_d    = 5'd1;
                    count_finish_d = 5'd1;
                    acc_d          = '0;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    out_valid_d = 1'b1;
                    out_idx_d   = count_finish_q;
                    out_data_d  = sat;
                    acc_d       = '0;
                    if (last_neuron) begin
                        state_d        = S_IDLE;
                        done_d         = 1'b1;
                        count_ful_d    = 5'd0;
                        count_finish_d = 5'd0;
                    end else begin
                        count_ful_d    = 5'd1;
                        count_finish_d = count_finish_q + 5'd1;
                    end
                end else begin
                    acc_d       = total;
                    count_ful_d = count_ful_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            count_ful_q    <= '0;
            count_finish_q <= '0;
            acc_q          <= '0;
            out_valid_q    <= 1'b0;
            done_q         <= 1'b0;
            out_idx_q      <= '0;
            out_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            count_ful_q    <= count_ful_d;
            count_finish_q <= count_finish_d;
            acc_q          <= acc_d;
            out_valid_q    <= out_valid_d;
            done_q         <= done_d;
            out_idx_q      <= out_idx_d;
            out_data_q     <= out_data_d;
        end
    end

    assign count_ful    = count_ful_q;
    assign count_finish = count_finish_q;
    assign busy         = (state_q == S_RUN);
    assign out_valid    = out_valid_q;
    assign out_idx      = out_idx_q;
    assign out_data     = out_data_q;
    assign done         = done_q;

endmodule

// File: tb/tb_ful_mac_ctrl.sv
// tb/tb_ful_mac_ctrl.sv - directed self-checking bench for ful_mac_ctrl
module tb_ful_mac_ctrl;
    logic               clk;
    logic               rst;
    logic               start;
    logic               feat_wr_en;
    logic [4:0]         feat_wr_addr;
    logic signed [15:0] feat_wr_data [3:1];
    logic [4:0]         count_ful;
    logic [4:0]         count_finish;
    logic signed [15:0] weight_ful1 [3:1];
    logic               busy;
    logic               out_valid;
    logic [4:0]         out_idx;
    logic signed [15:0] out_data;
    logic               done;

    int                 n_checks;
    int                 n_errors;
    int                 rom_mode;
    logic signed [15:0] wval;

    ful_mac_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .feat_wr_en   (feat_wr_en),
        .feat_wr_addr (feat_wr_addr),
        .feat_wr_data (feat_wr_data),
        .count_ful    (count_ful),
        .count_finish (count_finish),
        .weight_ful1  (weight_ful1),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_idx      (out_idx),
        .out_data     (out_data),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // weight ROM model: zero at step 0, else constant or index-dependent
    always_comb begin
        for (int g = 1; g <= 3; g++) begin
            weight_ful1[g] = '0;
            if (count_ful != 5'd0) begin
                if (rom_mode == 0)
                    weight_ful1[g] = wval;
                else
                    weight_ful1[g] = 16'(g * 1000 + int'(count_ful) * 30 + int'(count_finish));
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_addr(input int a, input logic signed [15:0] d1,
                              input logic signed [15:0] d2, input logic signed [15:0] d3);
        @(negedge clk);
        feat_wr_en      = 1'b1;
        feat_wr_addr    = 5'(a);
        feat_wr_data[1] = d1;
        feat_wr_data[2] = d2;
        feat_wr_data[3] = d3;
        @(negedge clk);
        feat_wr_en = 1'b0;
    endtask

    task automatic load_all(input logic signed [15:0] v);
        for (int a = 1; a <= 30; a++)
            write_addr(a, v, v, v);
    endtask

    task automatic pulse_rst(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // cyc counts so that start sampled at edge 0 gives cyc==1 just after that edge
    task automatic do_run(input string tag, input int exp_const, input bit use_index,
                          input int inj, input int abort_at);
        int cyc;
        int nvalid;
        int ndone;
        int exp_d;
        bit fin;
        nvalid = 0;
        ndone  = 0;
        fin    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;
        check({tag, " busy_c1"}, int'(busy), 1);
        check({tag, " ful_c1"}, int'(count_ful), 1);
        check({tag, " fin_c1"}, int'(count_finish), 1);
        while (cyc < 520 && !fin) begin
            if (out_valid) begin
                nvalid++;
                exp_d = use_index ? (2210 + nvalid) : exp_const;
                check({tag, " out_idx"}, int'(out_idx), nvalid);
                check({tag, " out_data"}, int'(out_data), exp_d);
                check({tag, " valid_cycle"}, cyc, 30 * nvalid + 1);
            end
            if (done) begin
                ndone++;
                check({tag, " done_cycle"}, cyc, 481);
                check({tag, " done_with_valid"}, int'(out_valid), 1);
                fin = 1'b1;
            end
            if (abort_at == 0 && cyc == 30)
                check({tag, " ful_wrap_pre"}, int'(count_ful), 30);
            if (abort_at == 0 && cyc == 31) begin
                check({tag, " ful_wrap"}, int'(count_ful), 1);
                check({tag, " fin_incr"}, int'(count_finish), 2);
            end
            if (abort_at > 0 && cyc == abort_at + 1) begin
                check({tag, " abort_busy"}, int'(busy), 0);
                check({tag, " abort_ful"}, int'(count_ful), 0);
                check({tag, " abort_fin"}, int'(count_finish), 0);
            end
            if (abort_at > 0 && cyc == abort_at + 40)
                fin = 1'b1;
            if (cyc == inj) begin
                start           = 1'b1;
                feat_wr_en      = 1'b1;
                feat_wr_addr    = 5'd7;
                feat_wr_data[1] = 16'sd1000;
                feat_wr_data[2] = 16'sd1000;
                feat_wr_data[3] = 16'sd1000;
            end else begin
                start      = 1'b0;
                feat_wr_en = 1'b0;
            end
            rst = (abort_at > 0 && cyc == abort_at);
            @(posedge clk);
            #1;
            cyc++;
        end
        rst        = 1'b0;
        start      = 1'b0;
        feat_wr_en = 1'b0;
        if (abort_at > 0) begin
            check({tag, " abort_nvalid"}, nvalid, 3);
            check({tag, " abort_ndone"}, ndone, 0);
        end else begin
            check({tag, " nvalid"}, nvalid, 16);
            check({tag, " ndone"}, ndone, 1);
            check({tag, " idle_busy"}, int'(busy), 0);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rom_mode        = 0;
        wval            = 16'sd256;
        rst             = 1'b1;
        start           = 1'b0;
        feat_wr_en      = 1'b0;
        feat_wr_addr    = '0;
        feat_wr_data[1] = '0;
        feat_wr_data[2] = '0;
        feat_wr_data[3] = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst busy", int'(busy), 0);
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_idx", int'(out_idx), 0);
        check("rst out_data", int'(out_data), 0);
        check("rst done", int'(done), 0);
        check("rst count_ful", int'(count_ful), 0);
        check("rst count_finish", int'(count_finish), 0);
        @(posedge clk);
        #1;
        check("idle count_ful", int'(count_ful), 0);
        check("idle busy", int'(busy), 0);

        load_all(16'sd256);
        pulse_rst(1);
        do_run("rstclr", 0, 1'b0, 0, 0);

        load_all(16'sd256);
        write_addr(0, 16'sd1000, 16'sd1000, 16'sd1000);
        write_addr(31, 16'sd1000, 16'sd1000, 16'sd1000);
        do_run("nom", 23040, 1'b0, 0, 0);

        do_run("proto", 23040, 1'b0, 50, 0);

        load_all(16'sd32767);
        wval = 16'sd32767;
        do_run("satpos", 32767, 1'b0, 0, 0);

        load_all(-16'sd32768);
        do_run("satneg", -32768, 1'b0, 0, 0);

        load_all(16'sd0);
        write_addr(7, 16'sd0, 16'sd256, 16'sd0);
        rom_mode = 1;
        do_run("index", 0, 1'b1, 0, 0);

        rom_mode = 0;
        wval     = 16'sd256;
        load_all(16'sd256);
        do_run("abort", 23040, 1'b0, 0, 100);
        load_all(16'sd256);
        do_run("rerun", 23040, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
